// File: rtl/bank_write_arbiter_pkg.sv
// ============================================================================
// Module      : bank_write_arbiter_pkg
// Description : Shared widths, write-beat type and defaults for the bank
//               write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bank_write_arbiter_pkg;

    localparam int DATA_W             = 64;
    localparam int ADDR_W             = 9;
    localparam int MASK_W             = 8;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] address;
        logic [MASK_W-1:0] mask;
    } wr_beat_t;

    localparam int BEAT_W = $bits(wr_beat_t);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_E    = 2'd1,
        GNT_O    = 2'd2,
        GNT_LIT  = 2'd3
    } grant_e;

endpackage

`default_nettype wire

// File: rtl/wr_fifo.sv
// ============================================================================
// Module      : wr_fifo
// Description : Synchronous FIFO with occupancy count and same-cycle push/pop;
//               a push into a full FIFO is taken only if it pops that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_push_ok,
    output logic             o_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop_ok;

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_pop_ok   = i_pop & ~o_empty;
    assign o_push_ok  = i_push & (~o_full | w_pop_ok);
    assign o_drop     = i_push & o_full & ~w_pop_ok;
    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (o_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CNT_W'(o_push_ok) - CNT_W'(w_pop_ok);
        end
    end

    // Storage carries no reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (o_push_ok) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

`default_nettype wire

// File: rtl/bank_write_arbiter.sv
// ============================================================================
// Module      : bank_write_arbiter
// Description : Merges two copy-result streams and a literal write stream onto
//               one registered RAM bank write port. Optional grant counters
//               are enabled by BANK_WRITE_ARBITER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bank_write_arbiter
    import bank_write_arbiter_pkg::*;
#(
    parameter logic [3:0] BLOCKNUM   = 4'd0,
    parameter int         FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clean_busy_in,
    input  logic              lit_valid_in,
    output logic              lit_ready_out,
    input  logic [DATA_W-1:0] lit_data_in,
    input  logic [ADDR_W-1:0] lit_address_in,
    input  logic [MASK_W-1:0] lit_mask_in,
    input  logic              even_valid_in,
    input  logic [DATA_W-1:0] even_data_in,
    input  logic [MASK_W-1:0] even_hit_in,
    input  logic [ADDR_W-1:0] even_address_in,
    input  logic              odd_valid_in,
    input  logic [DATA_W-1:0] odd_data_in,
    input  logic [MASK_W-1:0] odd_hit_in,
    input  logic [ADDR_W-1:0] odd_address_in,
    output logic              wr_valid_out,
    output logic [DATA_W-1:0] wr_data_out,
    output logic [ADDR_W-1:0] wr_address_out,
    output logic [MASK_W-1:0] wr_mask_out,
    output logic              stall_out,
    output logic              overflow_err_out
`ifdef BANK_WRITE_ARBITER_STATS_EN
    ,
    output logic [15:0]       lit_grant_cnt_out,
    output logic [15:0]       copy_grant_cnt_out
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
        (int'(BLOCKNUM) > 15)) begin : g_bad_cfg
        $error("bank_write_arbiter: FIFO_DEPTH must be a power of two >= 4");
    end

    wr_beat_t         w_e_in, w_o_in, w_e_head, w_o_head;
    logic             w_e_push, w_o_push, w_e_pop, w_o_pop;
    logic             w_e_full, w_o_full, w_e_empty, w_o_empty;
    logic             w_e_push_ok, w_o_push_ok, w_e_drop, w_o_drop;
    logic [CNT_W-1:0] w_e_count, w_o_count, w_e_cnt_nxt, w_o_cnt_nxt;
    grant_e           w_grant;
    logic             w_rr_toggle;
    logic             r_rr;

    // A zero hit mask means nothing to write, so it never occupies a slot.
    assign w_e_push = even_valid_in & (|even_hit_in);
    assign w_o_push = odd_valid_in & (|odd_hit_in);
    assign w_e_in   = '{data: even_data_in, address: even_address_in, mask: even_hit_in};
    assign w_o_in   = '{data: odd_data_in, address: odd_address_in, mask: odd_hit_in};

    wr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(BEAT_W), .CNT_W(CNT_W)) u_fifo_e (
        .clk(clk), .rst(rst),
        .i_push(w_e_push), .i_push_data(w_e_in), .i_pop(w_e_pop),
        .o_pop_data(w_e_head), .o_count(w_e_count), .o_full(w_e_full),
        .o_empty(w_e_empty), .o_push_ok(w_e_push_ok), .o_drop(w_e_drop)
    );

    wr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(BEAT_W), .CNT_W(CNT_W)) u_fifo_o (
        .clk(clk), .rst(rst),
        .i_push(w_o_push), .i_push_data(w_o_in), .i_pop(w_o_pop),
        .o_pop_data(w_o_head), .o_count(w_o_count), .o_full(w_o_full),
        .o_empty(w_o_empty), .o_push_ok(w_o_push_ok), .o_drop(w_o_drop)
    );

    assign lit_ready_out = ~clean_busy_in & w_e_empty & w_o_empty;

    always_comb begin
        w_grant     = GNT_NONE;
        w_rr_toggle = 1'b0;
        if (!clean_busy_in) begin
            if (!w_e_empty && !w_o_empty) begin
                w_grant     = r_rr ? GNT_O : GNT_E;
                w_rr_toggle = 1'b1;
            end else if (!w_e_empty) begin
                w_grant = GNT_E;
            end else if (!w_o_empty) begin
                w_grant = GNT_O;
            end else if (lit_valid_in) begin
                w_grant = GNT_LIT;
            end
        end
    end

    assign w_e_pop = (w_grant == GNT_E);
    assign w_o_pop = (w_grant == GNT_O);

    // Stall looks at next-cycle occupancy so the two in-flight beats still fit.
    assign w_e_cnt_nxt = w_e_count + CNT_W'(w_e_push_ok) - CNT_W'(w_e_pop);
    assign w_o_cnt_nxt = w_o_count + CNT_W'(w_o_push_ok) - CNT_W'(w_o_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr             <= 1'b0;
            wr_valid_out     <= 1'b0;
            wr_data_out      <= '0;
            wr_address_out   <= '0;
            wr_mask_out      <= '0;
            stall_out        <= 1'b0;
            overflow_err_out <= 1'b0;
        end else begin
            if (w_rr_toggle) r_rr <= ~r_rr;
            wr_valid_out <= (w_grant != GNT_NONE);
            case (w_grant)
                GNT_E: begin
                    wr_data_out    <= w_e_head.data;
                    wr_address_out <= w_e_head.address;
                    wr_mask_out    <= w_e_head.mask;
                end
                GNT_O: begin
                    wr_data_out    <= w_o_head.data;
                    wr_address_out <= w_o_head.address;
                    wr_mask_out    <= w_o_head.mask;
                end
                GNT_LIT: begin
                    wr_data_out    <= lit_data_in;
                    wr_address_out <= lit_address_in;
                    wr_mask_out    <= lit_mask_in;
                end
                default: ;
            endcase
            stall_out <= (w_e_cnt_nxt >= CNT_W'(FIFO_DEPTH - 2)) |
                         (w_o_cnt_nxt >= CNT_W'(FIFO_DEPTH - 2));
            if (w_e_drop || w_o_drop) overflow_err_out <= 1'b1;
        end
    end

`ifdef BANK_WRITE_ARBITER_STATS_EN
    logic [15:0] r_lit_cnt, r_copy_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lit_cnt  <= '0;
            r_copy_cnt <= '0;
        end else begin
            if (w_grant == GNT_LIT && r_lit_cnt != 16'hFFFF)
                r_lit_cnt <= r_lit_cnt + 16'd1;
            if ((w_grant == GNT_E || w_grant == GNT_O) && r_copy_cnt != 16'hFFFF)
                r_copy_cnt <= r_copy_cnt + 16'd1;
        end
    end

    assign lit_grant_cnt_out  = r_lit_cnt;
    assign copy_grant_cnt_out = r_copy_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bank_write_arbiter.sv
// ============================================================================
// Module      : tb_bank_write_arbiter
// Description : Directed self-checking bench for bank_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bank_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        clean_busy_in;
    logic        lit_valid_in;
    logic        lit_ready_out;
    logic [63:0] lit_data_in;
    logic [8:0]  lit_address_in;
    logic [7:0]  lit_mask_in;
    logic        even_valid_in;
    logic [63:0] even_data_in;
    logic [7:0]  even_hit_in;
    logic [8:0]  even_address_in;
    logic        odd_valid_in;
    logic [63:0] odd_data_in;
    logic [7:0]  odd_hit_in;
    logic [8:0]  odd_address_in;
    logic        wr_valid_out;
    logic [63:0] wr_data_out;
    logic [8:0]  wr_address_out;
    logic [7:0]  wr_mask_out;
    logic        stall_out;
    logic        overflow_err_out;
`ifdef BANK_WRITE_ARBITER_STATS_EN
    logic [15:0] lit_grant_cnt_out;
    logic [15:0] copy_grant_cnt_out;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bank_write_arbiter #(.BLOCKNUM(4'd0), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .clean_busy_in(clean_busy_in),
        .lit_valid_in(lit_valid_in), .lit_ready_out(lit_ready_out),
        .lit_data_in(lit_data_in), .lit_address_in(lit_address_in),
        .lit_mask_in(lit_mask_in),
        .even_valid_in(even_valid_in), .even_data_in(even_data_in),
        .even_hit_in(even_hit_in), .even_address_in(even_address_in),
        .odd_valid_in(odd_valid_in), .odd_data_in(odd_data_in),
        .odd_hit_in(odd_hit_in), .odd_address_in(odd_address_in),
        .wr_valid_out(wr_valid_out), .wr_data_out(wr_data_out),
        .wr_address_out(wr_address_out), .wr_mask_out(wr_mask_out),
        .stall_out(stall_out), .overflow_err_out(overflow_err_out)
`ifdef BANK_WRITE_ARBITER_STATS_EN
        ,
        .lit_grant_cnt_out(lit_grant_cnt_out),
        .copy_grant_cnt_out(copy_grant_cnt_out)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic even_beat(input logic [63:0] d, input logic [7:0] h, input logic [8:0] a);
        even_valid_in   = 1'b1;
        even_data_in    = d;
        even_hit_in     = h;
        even_address_in = a;
    endtask

    logic [63:0] rr_exp [6];

    initial begin
        rst = 1'b1; clean_busy_in = 1'b0;
        lit_valid_in = 1'b0; lit_data_in = '0; lit_address_in = '0; lit_mask_in = '0;
        even_valid_in = 1'b0; even_data_in = '0; even_hit_in = '0; even_address_in = '0;
        odd_valid_in = 1'b0; odd_data_in = '0; odd_hit_in = '0; odd_address_in = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_wr_valid", 64'(wr_valid_out), 64'd0);
        chk("rst_wr_data", wr_data_out, 64'd0);
        chk("rst_wr_addr", 64'(wr_address_out), 64'd0);
        chk("rst_wr_mask", 64'(wr_mask_out), 64'd0);
        chk("rst_stall", 64'(stall_out), 64'd0);
        chk("rst_ovf", 64'(overflow_err_out), 64'd0);
        chk("rst_lit_ready", 64'(lit_ready_out), 64'd1);

        // Single literal
        lit_valid_in = 1'b1; lit_data_in = 64'hA5A5_0000_1234_5678;
        lit_address_in = 9'h005; lit_mask_in = 8'h0F;
        #1 chk("lit_ready", 64'(lit_ready_out), 64'd1);
        tick();
        lit_valid_in = 1'b0;
        chk("lit_wr_valid", 64'(wr_valid_out), 64'd1);
        chk("lit_wr_addr", 64'(wr_address_out), 64'h005);
        chk("lit_wr_mask", 64'(wr_mask_out), 64'h0F);
        chk("lit_wr_data", wr_data_out, 64'hA5A5_0000_1234_5678);
        tick();
        chk("lit_idle", 64'(wr_valid_out), 64'd0);

        // Round-robin: three simultaneous even/odd pushes
        rr_exp = '{64'd100, 64'd200, 64'd101, 64'd201, 64'd102, 64'd202};
        odd_hit_in = 8'h3C;
        even_beat(64'd100, 8'hFF, 9'd10);
        odd_valid_in = 1'b1; odd_data_in = 64'd200; odd_address_in = 9'd20;
        tick();
        chk("rr_first_gap", 64'(wr_valid_out), 64'd0);
        chk("rr_lit_blocked0", 64'(lit_ready_out), 64'd0);
        even_beat(64'd101, 8'hFF, 9'd11);
        odd_data_in = 64'd201; odd_address_in = 9'd21;
        tick();
        chk("rr_gnt0", wr_data_out, rr_exp[0]);
        chk("rr_gnt0_mask", 64'(wr_mask_out), 64'hFF);
        even_beat(64'd102, 8'hFF, 9'd12);
        odd_data_in = 64'd202; odd_address_in = 9'd22;
        tick();
        even_valid_in = 1'b0; odd_valid_in = 1'b0;
        chk("rr_gnt1", wr_data_out, rr_exp[1]);
        chk("rr_gnt1_addr", 64'(wr_address_out), 64'd20);
        chk("rr_gnt1_mask", 64'(wr_mask_out), 64'h3C);
        for (int k = 2; k < 6; k++) begin
            chk("rr_lit_blocked", 64'(lit_ready_out), 64'd0);
            tick();
            chk("rr_valid", 64'(wr_valid_out), 64'd1);
            chk("rr_gnt", wr_data_out, rr_exp[k]);
        end
        chk("rr_lit_ready_after", 64'(lit_ready_out), 64'd1);
        tick();
        chk("rr_idle", 64'(wr_valid_out), 64'd0);

        // Clean hold: 10 cycles of clean with two even beats arriving
        clean_busy_in = 1'b1;
        lit_valid_in = 1'b1; lit_address_in = 9'h1FF;
        tick();
        chk("cl_nowr0", 64'(wr_valid_out), 64'd0);
        even_beat(64'd300, 8'h0F, 9'd30);
        tick();
        chk("cl_nowr1", 64'(wr_valid_out), 64'd0);
        even_beat(64'd301, 8'hF0, 9'd31);
        tick();
        even_valid_in = 1'b0;
        chk("cl_nowr2", 64'(wr_valid_out), 64'd0);
        for (int k = 0; k < 7; k++) begin
            chk("cl_lit_ready", 64'(lit_ready_out), 64'd0);
            tick();
            chk("cl_nowr", 64'(wr_valid_out), 64'd0);
        end
        clean_busy_in = 1'b0; lit_valid_in = 1'b0;
        tick();
        chk("cl_wr0_valid", 64'(wr_valid_out), 64'd1);
        chk("cl_wr0", wr_data_out, 64'd300);
        chk("cl_wr0_mask", 64'(wr_mask_out), 64'h0F);
        tick();
        chk("cl_wr1", wr_data_out, 64'd301);
        chk("cl_wr1_valid", 64'(wr_valid_out), 64'd1);
        tick();
        chk("cl_idle", 64'(wr_valid_out), 64'd0);
        chk("cl_stall_clear", 64'(stall_out), 64'd0);

        // Stall and overflow: five pushes into a depth-4 FIFO during clean
        clean_busy_in = 1'b1;
        even_beat(64'd400, 8'h01, 9'd40);
        tick();
        chk("st_after1", 64'(stall_out), 64'd0);
        even_beat(64'd401, 8'h01, 9'd41);
        tick();
        chk("st_after2", 64'(stall_out), 64'd1);
        even_beat(64'd402, 8'h01, 9'd42);
        tick();
        even_beat(64'd403, 8'h01, 9'd43);
        tick();
        chk("ov_full_no_err", 64'(overflow_err_out), 64'd0);
        even_beat(64'd404, 8'h01, 9'd44);
        tick();
        even_valid_in = 1'b0;
        chk("ov_err", 64'(overflow_err_out), 64'd1);
        clean_busy_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ov_drain", wr_data_out, 64'd400 + 64'(k));
        end
        tick();
        chk("ov_fifth_dropped", 64'(wr_valid_out), 64'd0);
        chk("ov_stall_off", 64'(stall_out), 64'd0);

        // Zero-hit beat is never written
        even_beat(64'd500, 8'h00, 9'd50);
        tick();
        even_valid_in = 1'b0;
        chk("zh_lit_ready", 64'(lit_ready_out), 64'd1);
        chk("zh_nowr0", 64'(wr_valid_out), 64'd0);
        tick();
        chk("zh_nowr1", 64'(wr_valid_out), 64'd0);
        chk("ovf_sticky", 64'(overflow_err_out), 64'd1);

        // Reset mid-burst
        clean_busy_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            even_beat(64'd600 + 64'(k), 8'hFF, 9'd60);
            tick();
        end
        even_valid_in = 1'b0;
        chk("mr_stall_before", 64'(stall_out), 64'd1);
        rst = 1'b1;
        tick();
        chk("mr_wr_valid", 64'(wr_valid_out), 64'd0);
        chk("mr_wr_data", wr_data_out, 64'd0);
        chk("mr_wr_addr", 64'(wr_address_out), 64'd0);
        chk("mr_wr_mask", 64'(wr_mask_out), 64'd0);
        chk("mr_stall", 64'(stall_out), 64'd0);
        chk("mr_ovf", 64'(overflow_err_out), 64'd0);
        rst = 1'b0; clean_busy_in = 1'b0;
        #1 chk("mr_fifos_empty", 64'(lit_ready_out), 64'd1);
        tick();
        chk("mr_no_drain", 64'(wr_valid_out), 64'd0);

`ifdef BANK_WRITE_ARBITER_STATS_EN
        // Grant counters: 3 literal grants then 2 copy grants
        lit_valid_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            lit_address_in = 9'(k);
            tick();
        end
        lit_valid_in = 1'b0;
        even_beat(64'd700, 8'h11, 9'd70);
        tick();
        even_beat(64'd701, 8'h11, 9'd71);
        tick();
        even_valid_in = 1'b0;
        tick(); tick();
        chk("stat_lit", 64'(lit_grant_cnt_out), 64'd3);
        chk("stat_copy", 64'(copy_grant_cnt_out), 64'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
